// File: rtl/sfu_pkg.sv
// rtl/sfu_pkg.sv - shared SFU types, constants and normalize/round stage payloads
package sfu_pkg;

  localparam int SFU_IN_W  = 50;
  localparam int SFU_IN_FL = 46;
  localparam int SFU_EXP_W = 10;
  localparam int FP32_BIAS = 127;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    SP_NONE = 2'b00,
    SP_ZERO = 2'b01,
    SP_INF  = 2'b10,
    SP_NAN  = 2'b11
  } special_e;

  // Operation codes shared with the SFU control path.
  typedef enum logic [2:0] {
    OP_RCP     = 3'd0,
    OP_RSQ     = 3'd1,
    OP_SQRT    = 3'd2,
    OP_LOG2    = 3'd3,
    OP_EXP2    = 3'd4,
    OP_SIN     = 3'd5,
    OP_COS     = 3'd6,
    OP_SIGMOID = 3'd7
  } sfu_op_e;

  // Stage 1: magnitude and leading-one position of the approximation.
  typedef struct packed {
    logic [SFU_IN_W-1:0]  mag;
    logic                 s;
    logic [6:0]           p;          // signed, leading-one weight 3..-46
    logic [SFU_EXP_W-1:0] exp_base;   // signed
    logic                 precision;
    special_e             special;
    logic                 zero_flag;
  } nr_s1_t;

  // Stage 2: normalised fraction with rounding bits and biased exponent.
  typedef struct packed {
    logic [22:0] frac;
    logic        guard;
    logic        sticky;
    logic [11:0] e;                   // signed, biased
    logic        s;
    logic        precision;
    special_e    special;
    logic        zero_flag;
  } nr_s2_t;

endpackage

// File: rtl/sfu_lzc50.sv
// rtl/sfu_lzc50.sv - leading-one position of a 50-bit magnitude
module sfu_lzc50 #(
  parameter int FL = 46
) (
  input  logic [49:0] value,
  output logic [6:0]  p,
  output logic        zero_flag
);

  logic [5:0] idx;

  // Scan upward so the highest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = 0; i < 50; i++) begin
      if (value[i]) idx = 6'(i);
    end
  end

  // Convert the bit index into its weight relative to the binary point.
  assign p         = {1'b0, idx} - 7'(FL);
  assign zero_flag = (value == '0);

endmodule

// File: rtl/sfu_normalize_round.sv
// rtl/sfu_normalize_round.sv - normalise, round and pack the SFU approximation to binary32
module sfu_normalize_round
  import sfu_pkg::*;
#(
  parameter int IN_W  = SFU_IN_W,
  parameter int IN_FL = SFU_IN_FL,
  parameter int EXP_W = SFU_EXP_W,
  parameter int BIAS  = FP32_BIAS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  approx_result,
  input  logic [EXP_W-1:0] exp_base,
  input  logic             sign_in,
  input  logic             precision,
  input  logic [1:0]       special,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [2:0]       out_flags
);

  logic   v1, v2, v3;
  logic   adv1, adv2, adv3, accept;
  nr_s1_t s1, s1_c;
  nr_s2_t s2, s2_c;

  // Each stage moves on when the stage after it is empty or moving itself.
  assign adv3     = v3 && out_ready;
  assign adv2     = v2 && (!v3 || adv3);
  assign adv1     = v1 && (!v2 || adv2);
  assign in_ready = !v1 || adv1;
  assign accept   = in_valid && in_ready;
  assign out_valid = v3;

  // ---------------- stage 1: magnitude + leading-one search ----------------
  logic [IN_W-1:0] mag_c;
  logic [6:0]      lzc_p;
  logic            lzc_zero;

  // Two's complement magnitude; -8.0 maps onto the unsigned value 8.0.
  assign mag_c = approx_result[IN_W-1] ? (~approx_result + {{(IN_W-1){1'b0}}, 1'b1})
                                       : approx_result;

  sfu_lzc50 #(.FL(IN_FL)) u_lzc (
    .value     (mag_c),
    .p         (lzc_p),
    .zero_flag (lzc_zero)
  );

  // Assemble the stage 1 payload from the incoming beat.
  always_comb begin
    s1_c           = '0;
    s1_c.mag       = mag_c;
    s1_c.s         = sign_in ^ approx_result[IN_W-1];
    s1_c.p         = lzc_p;
    s1_c.exp_base  = exp_base;
    s1_c.precision = precision;
    s1_c.special   = special_e'(special);
    s1_c.zero_flag = lzc_zero;
  end

  // Stage 1 register: capture accepted beats, empty when drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      s1 <= '0;
    end else if (accept) begin
      v1 <= 1'b1;
      s1 <= s1_c;
    end else if (adv1) begin
      v1 <= 1'b0;
    end
  end

  // ---------------- stage 2: normalising shift + exponent ----------------
  logic [6:0]      shamt;
  logic [IN_W-1:0] norm;
  logic [11:0]     e_sum;

  // Bring the leading one up to the top bit of the word.
  assign shamt = 7'(IN_W - 1 - IN_FL) - s1.p;
  assign norm  = s1.mag << shamt;

  // Sign-extend both operands into 12 bits so no sum can wrap.
  assign e_sum = {{(12-EXP_W){s1.exp_base[EXP_W-1]}}, s1.exp_base}
               + {{5{s1.p[6]}}, s1.p}
               + 12'(BIAS);

  // Split the normalised word into fraction, guard and sticky.
  always_comb begin
    s2_c           = '0;
    s2_c.frac      = norm[IN_W-2 -: 23];
    s2_c.guard     = norm[IN_W-25];
    s2_c.sticky    = |norm[IN_W-26:0];
    s2_c.e         = e_sum;
    s2_c.s         = s1.s;
    s2_c.precision = s1.precision;
    s2_c.special   = s1.special;
    // A missing leading one after the shift also means a zero magnitude.
    s2_c.zero_flag = s1.zero_flag || !norm[IN_W-1];
  end

  // Stage 2 register: take stage 1's payload when it advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2 <= 1'b0;
      s2 <= '0;
    end else if (adv1) begin
      v2 <= 1'b1;
      s2 <= s2_c;
    end else if (adv2) begin
      v2 <= 1'b0;
    end
  end

  // ---------------- stage 3: round + pack ----------------
  logic        round_inc, inexact;
  logic [23:0] frac_sum;
  logic [11:0] e_rnd;
  logic [31:0] data_c;
  logic [2:0]  flags_c;

  assign round_inc = s2.precision && s2.guard && (s2.sticky || s2.frac[0]);
  assign frac_sum  = {1'b0, s2.frac} + {23'd0, round_inc};
  // A mantissa carry leaves the fraction at zero and bumps the exponent.
  assign e_rnd     = s2.e + {11'd0, frac_sum[23]};
  assign inexact   = s2.guard || s2.sticky;

  // Special tags take priority over the arithmetic result.
  always_comb begin
    data_c  = '0;
    flags_c = '0;
    case (s2.special)
      SP_NAN:  data_c = QNAN;
      SP_INF:  data_c = {s2.s, 8'hFF, 23'd0};
      SP_ZERO: data_c = {s2.s, 31'd0};
      default: begin
        if (s2.zero_flag) begin
          data_c = {s2.s, 31'd0};
        end else if ($signed(e_rnd) >= 12'sd255) begin
          data_c  = {s2.s, 8'hFF, 23'd0};
          flags_c = 3'b101;
        end else if ($signed(e_rnd) <= 12'sd0) begin
          data_c  = {s2.s, 31'd0};
          flags_c = 3'b011;
        end else begin
          data_c  = {s2.s, e_rnd[7:0], frac_sum[22:0]};
          flags_c = {2'b00, inexact};
        end
      end
    endcase
  end

  // Output register: holds its value while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3        <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else if (adv2) begin
      v3        <= 1'b1;
      out_data  <= data_c;
      out_flags <= flags_c;
    end else if (adv3) begin
      v3 <= 1'b0;
    end
  end

endmodule
